// File: rtl/keccak_pkg.sv
// keccak_pkg: mode encodings, digest length lookup and driver state type shared by the keccak host driver.
package keccak_pkg;
  localparam logic [1:0] MODE_224 = 2'b00;
  localparam logic [1:0] MODE_256 = 2'b01;
  localparam logic [1:0] MODE_384 = 2'b10;
  localparam logic [1:0] MODE_512 = 2'b11;
  typedef enum logic [2:0] {S_IDLE, S_START, S_FEED, S_WAIT, S_DRAIN} drv_state_e;
  function automatic logic [3:0] digest_words(input logic [1:0] mode);
    return mode == MODE_512 ? 4'd8 : mode == MODE_384 ? 4'd6 : 4'd4;
  endfunction
endpackage

// File: rtl/keccak_digest_skid.sv
// keccak_digest_skid: one-entry digest output register that pulls words from the core with gimme.
module keccak_digest_skid #(
  parameter int WORD_W = 64,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic [CNT_W-1:0]  i_n,
  input  logic [WORD_W-1:0] i_out,
  input  logic              i_buf_empty,
  input  logic              i_m_ready,
  output logic              o_gimme,
  output logic [WORD_W-1:0] o_m_data,
  output logic              o_m_valid,
  output logic              o_m_last,
  output logic              o_done,
  output logic              o_err
);
  logic [CNT_W-1:0]  r_cnt;
  logic [WORD_W-1:0] r_data;
  logic              r_valid;
  logic              r_last;
  logic              w_need;
  assign w_need    = i_en && (!r_valid || i_m_ready) && (r_cnt < i_n);
  assign o_gimme   = w_need && !i_buf_empty;
  assign o_err     = w_need && i_buf_empty;
  assign o_done    = r_valid && i_m_ready && r_last;
  assign o_m_data  = r_data;
  assign o_m_valid = r_valid;
  assign o_m_last  = r_last;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (!i_en || o_err) begin
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (o_gimme) begin
      r_data  <= i_out;
      r_valid <= 1'b1;
      r_cnt   <= r_cnt + CNT_W'(1);
      r_last  <= (r_cnt + CNT_W'(1)) == i_n;
    end else if (r_valid && i_m_ready) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end
endmodule

// File: rtl/keccak_host_driver.sv
// keccak_host_driver: streams host message words into the keccak core and re-streams its digest.
// Define KECCAK_DRV_TIMEOUT_EN to add a WAIT_HASH watchdog of TIMEOUT_CYCLES cycles.
module keccak_host_driver
  import keccak_pkg::*;
#(
  parameter int WORD_W         = 64,
  parameter int CNT_W          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_start,
  input  logic [1:0]        cmd_mode,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic              core_start_calc,
  output logic [1:0]        core_mode,
  output logic [WORD_W-1:0] core_in,
  output logic              core_in_valid,
  output logic              core_is_last,
  input  logic              core_ack,
  input  logic [WORD_W-1:0] core_out,
  input  logic              core_out_ready,
  input  logic              core_out_buf_empty,
  output logic              core_gimme,
  output logic [WORD_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);
  drv_state_e        r_state;
  logic [1:0]        r_mode;
  logic [WORD_W-1:0] r_in;
  logic              r_in_valid;
  logic              r_is_last;
  logic              r_last_taken;
  logic              r_done;
  logic              r_err;
  logic              w_s_fire;
  logic              w_skid_done;
  logic              w_skid_err;
  logic              w_timeout;
  assign s_ready         = (r_state == S_FEED) && !core_ack && !r_last_taken;
  assign w_s_fire        = s_valid && s_ready;
  assign core_start_calc = r_state == S_START;
  assign core_mode       = r_mode;
  assign core_in         = r_in;
  assign core_in_valid   = r_in_valid;
  assign core_is_last    = r_is_last;
  assign busy            = r_state != S_IDLE;
  assign done            = r_done;
  assign err             = r_err;
`ifdef KECCAK_DRV_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] r_to_cnt;
  assign w_timeout = (r_state == S_WAIT) && !core_out_ready && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_to_cnt <= '0;
    else      r_to_cnt <= (r_state == S_WAIT) ? r_to_cnt + TW'(1) : '0;
  end
`else
  assign w_timeout = 1'b0;
`endif
  keccak_digest_skid #(.WORD_W(WORD_W), .CNT_W(CNT_W)) u_skid (
    .clk         (clk),
    .rst         (rst),
    .i_en        (r_state == S_DRAIN),
    .i_n         (CNT_W'(digest_words(r_mode))),
    .i_out       (core_out),
    .i_buf_empty (core_out_buf_empty),
    .i_m_ready   (m_ready),
    .o_gimme     (core_gimme),
    .o_m_data    (m_data),
    .o_m_valid   (m_valid),
    .o_m_last    (m_last),
    .o_done      (w_skid_done),
    .o_err       (w_skid_err)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_mode       <= 2'b00;
      r_in         <= '0;
      r_in_valid   <= 1'b0;
      r_is_last    <= 1'b0;
      r_last_taken <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: if (cmd_start) begin
          r_mode       <= cmd_mode;
          r_last_taken <= 1'b0;
          r_state      <= S_START;
        end
        S_START: r_state <= S_FEED;
        S_FEED: if (w_s_fire) begin
          r_in         <= s_data;
          r_is_last    <= s_last;
          r_in_valid   <= 1'b1;
          r_last_taken <= s_last;
        end else if (!core_ack) begin
          // the core consumes the presented word on this edge
          r_in_valid <= 1'b0;
          r_is_last  <= 1'b0;
          if (r_in_valid && r_is_last) r_state <= S_WAIT;
        end
        S_WAIT: if (core_out_ready) r_state <= S_DRAIN;
        else if (w_timeout) begin
          r_err   <= 1'b1;
          r_state <= S_IDLE;
        end
        S_DRAIN: if (w_skid_done) begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end else if (w_skid_err) begin
          r_err   <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/keccak_host_driver.md
Name: keccak_host_driver

Overview:
- Host-side initiator for the keccak core's message/digest protocol.
- Turns a host valid/ready word stream into the core's start_calc / in / in_valid / is_last sequence, with backpressure from the core's ack.
- Waits for out_ready, then pulls the digest with gimme and re-streams it as a valid/ready output.
- Sits between the system bus adapter and the keccak core.

Parameters:
- WORD_W, 64, width of message and digest words; must match the core's in/out width.
- CNT_W, 4, width of the digest word counter; must hold the largest digest length (8).
- TIMEOUT_CYCLES, 1024, WAIT_HASH watchdog limit; used only with the optional feature.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-low reset.
- cmd_start  input  1  start a new hash; sampled only in IDLE.
- cmd_mode  input  2  digest select: 00=224, 01=256, 10=384, 11=512; latched on cmd_start.
- s_data  input  WORD_W  message word.
- s_valid  input  1  message word valid.
- s_last  input  1  final message word.
- s_ready  output  1  driver accepts a message word.
- core_start_calc  output  1  one-cycle start pulse to the core.
- core_mode  output  2  latched mode to the core.
- core_in  output  WORD_W  word to the core.
- core_in_valid  output  1  core_in valid.
- core_is_last  output  1  core_in is the final word.
- core_ack  input  1  core input full; hold the presented word.
- core_out  input  WORD_W  current digest word from the core.
- core_out_ready  input  1  digest available.
- core_out_buf_empty  input  1  core output buffer exhausted.
- core_gimme  output  1  request or advance one digest word.
- m_data  output  WORD_W  digest word.
- m_valid  output  1  digest word valid.
- m_last  output  1  final digest word.
- m_ready  input  1  sink accepts m_data.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse after the last digest word is accepted.
- err  output  1  one-cycle error pulse.

Behaviour:
- Reset (rst=0, asynchronous):
  - state returns to IDLE.
  - All outputs are 0; core_mode=00; counters cleared.
  - Applies mid-operation too; nothing is resumed.
- State machine:
  - IDLE: on cmd_start, latch cmd_mode and go to START. cmd_start in any other state is ignored.
  - START: core_start_calc=1 for exactly one cycle, then FEED.
  - FEED:
    - s_ready = (state==FEED) && !core_ack && !last_taken.
    - On s_valid&&s_ready: core_in<=s_data, core_is_last<=s_last, core_in_valid<=1 on the next edge (latency 1 cycle).
    - While core_ack=1, core_in, core_in_valid and core_is_last hold stable.
    - With no transfer and core_ack=0, core_in_valid<=0.
    - Once the is_last word has been presented with core_ack=0, go to WAIT_HASH.
  - WAIT_HASH: core_in_valid=0. When core_out_ready=1, go to DRAIN.
  - DRAIN:
    - Digest word count: 4 for mode 00 or 01, 6 for 10, 8 for 11.
    - One-entry output register. core_gimme=1 when the register is empty, or is being accepted (m_valid&&m_ready), and count < N.
    - At an edge where core_gimme=1, core_out is captured into m_data, m_valid<=1, count+1.
    - m_last=1 on word N.
    - When word N is accepted: done pulse, return to IDLE.
    - m_data and m_valid stay stable while m_ready=0.
  - core_out_buf_empty=1 while gimme is needed and count<N: err pulse, m_valid cleared, return to IDLE.
- Zero-length messages are not supported; the first word may carry s_last.
- Simultaneous s_valid with core_ack rising: the word already presented holds, and s_ready drops in the same cycle (combinational from core_ack).

Optional Feature:
- Macro: KECCAK_DRV_TIMEOUT_EN.
- Defined:
  - WAIT_HASH counts cycles; the counter is cleared on entry.
  - Reaching TIMEOUT_CYCLES without core_out_ready gives an err pulse and a return to IDLE.
- Undefined: no counter; WAIT_HASH waits indefinitely.

Decomposition:
- Shared package keccak_pkg:
  - mode encodings;
  - digest-word-count function (mode -> 4/4/6/8);
  - driver state enum.
- One natural sub-module: keccak_digest_skid, the one-entry output register with its gimme/valid/ready logic.
- FSM and input path stay in the top module.

Test Plan:
- Mode 01, six words from 64'hF0E1D2C3B4A59687 in steps of 64'h0101010101010101, last on word 6:
  - core_start_calc is a single pulse;
  - six core_in_valid beats in order, core_is_last only on beat 6;
  - core_out_ready stub, digest 64'hA0..A3 -> four m beats, m_last on the 4th, then a done pulse.
- core_ack held high for 3 cycles mid-message -> core_in stable across those cycles, s_ready=0, no word lost or duplicated.
- Mode 11 with m_ready toggling 1/0 -> 8 digest words, no duplicates; gimme never asserted while the register is held.
- core_out_buf_empty asserted after 2 digest words in mode 10 -> err pulse, IDLE, busy=0.
- rst low during FEED after 3 words -> all outputs 0 immediately; next cmd_start runs cleanly.
- With KECCAK_DRV_TIMEOUT_EN, TIMEOUT_CYCLES=16, core_out_ready never set -> err pulse 16 cycles after entering WAIT_HASH.
